seq_divider: RTL

Sequential unsigned restoring divider, the inverse operation of the team's 6x6 combinational multiplier. It divides a 12-bit dividend (one multiplier product width) by a 6-bit divisor and produces a 12-bit quotient and a 6-bit remainder, resolving one quotient bit per clock. A start/done handshake connects it to a controller or bench. Feeding it `X*Y` with divisor `Y` must return `X` exactly, with remainder 0.

---
 rtl/seq_divider.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential unsigned restoring divider, 12-bit dividend by 6-bit
//            divisor, one quotient bit per clock (MSB first). It is the inverse
//            of the 6x6 combinational multiplier: (X*Y)/Y returns X, rem 0.
// Ports    : clk          rising-edge clock
//            rst          asynchronous active-high reset
//            start        request pulse, sampled only in IDLE
//            dvdnd[11:0]  dividend, sampled with start
//            dvsr[5:0]    divisor, sampled with start
//            quot[11:0]   quotient, registered, updated on entry to DONE
//            rmndr[5:0]   remainder, registered, updated on entry to DONE
//            busy         high during the 12 CALC cycles
//            done         one-cycle pulse while results become valid
//            div_by_zero  set with done when divisor was 0, held until the
//                         next accepted start
// Revision : 1.0  initial release
// ============================================================================
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] dvdnd,
    input  logic [5:0]  dvsr,
    output logic [11:0] quot,
    output logic [5:0]  rmndr,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Dividend shift register; freed MSBs are refilled with quotient bits, so
    // after 12 shifts it holds the complete quotient.
    logic [11:0] dvd_sh;
    logic [5:0]  dvsr_q;
    // Partial remainder is always < divisor after a step, so 6 bits suffice;
    // only the trial value needs the seventh bit.
    logic [5:0]  pr;
    logic [3:0]  cnt;

    logic [6:0]  trial;
    logic [5:0]  diff;
    logic        q_bit;
    logic [5:0]  pr_nxt;
    logic        last_iter;

    // One restoring step
    always_comb begin
        trial     = {pr, dvd_sh[11]};
        q_bit     = (trial >= {1'b0, dvsr_q});
        // True difference is < 64 whenever it is used, so 6-bit wrap is exact.
        diff      = trial[5:0] - dvsr_q;
        pr_nxt    = q_bit ? diff : trial[5:0];
        last_iter = (cnt == 4'd11);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs (driven only by the state register)
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (dvsr == 6'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_sh      <= 12'd0;
            dvsr_q      <= 6'd0;
            pr          <= 6'd0;
            cnt         <= 4'd0;
            quot        <= 12'd0;
            rmndr       <= 6'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dvsr != 6'd0) begin
                            dvd_sh      <= dvdnd;
                            dvsr_q      <= dvsr;
                            pr          <= 6'd0;
                            cnt         <= 4'd0;
                            div_by_zero <= 1'b0;
                        end else begin
                            quot        <= 12'hFFF;
                            rmndr       <= 6'h3F;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_sh <= {dvd_sh[10:0], q_bit};
                    pr     <= pr_nxt;
                    cnt    <= cnt + 4'd1;
                    if (last_iter) begin
                        quot  <= {dvd_sh[10:0], q_bit};
                        rmndr <= pr_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
